dmem_arbiter: RTL and testbench

- Two-port arbiter and access sequencer for the single-port data memory.
- Port 0 serves the pipeline MEM stage; port 1 serves the debug/program loader.
- Requests use valid/ready handshakes and byte addresses with byte/half/word size. The block turns each request into one memory cycle: chip enable, write enable, 4-bit byte mask, word index and lane-replicated store data.
- Loads are returned lane-aligned and sign/zero-extended, with an error flag for illegal accesses.

---
 rtl/dmem_arbiter_pkg.sv | 28 ++
 rtl/dmem_lane_align.sv | 49 ++++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states
// and the captured-request record.
package dmem_arbiter_pkg;

  localparam int DWIDTH = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              isUnsigned;
    logic [31:0]       addr;
    logic [DWIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store mask and replicated data, load
// extraction with sign/zero extension, and the alignment check.
module dmem_lane_align
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        off_i,
  input  logic              unsigned_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [DWIDTH-1:0] rdata_i,
  output logic [3:0]        mask_o,
  output logic [DWIDTH-1:0] wdata_o,
  output logic [DWIDTH-1:0] load_o,
  output logic              misalign_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    mask_o     = '0;
    wdata_o    = '0;
    load_o     = '0;
    misalign_o = 1'b0;
    byteLane   = rdata_i[{off_i, 3'b000} +: 8];
    halfLane   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: begin
        mask_o  = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        load_o  = unsigned_i ? {24'b0, byteLane} : {{24{byteLane[7]}}, byteLane};
      end
      SZ_HALF: begin
        mask_o     = 4'b0011 << off_i;
        wdata_o    = {2{wdata_i[15:0]}};
        load_o     = unsigned_i ? {16'b0, halfLane} : {{16{halfLane[15]}}, halfLane};
        misalign_o = off_i[0];
      end
      SZ_WORD: begin
        mask_o     = 4'b1111;
        wdata_o    = wdata_i;
        load_o     = rdata_i;
        misalign_o = (off_i != 2'b00);
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter that turns each accepted request into a single
// registered memory cycle followed by a one-cycle response pulse.
module dmem_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int MEM_DEPTH = 32,
  parameter int IDX_W     = 5
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic              a_i_req0_valid,
  output logic              a_o_req0_ready,
  input  logic              a_i_req0_we,
  input  logic [1:0]        a_i_req0_size,
  input  logic              a_i_req0_unsigned,
  input  logic [31:0]       a_i_req0_addr,
  input  logic [DWIDTH-1:0] a_i_req0_wdata,
  input  logic              a_i_req1_valid,
  output logic              a_o_req1_ready,
  input  logic              a_i_req1_we,
  input  logic [1:0]        a_i_req1_size,
  input  logic              a_i_req1_unsigned,
  input  logic [31:0]       a_i_req1_addr,
  input  logic [DWIDTH-1:0] a_i_req1_wdata,
  output logic              a_o_rsp0_valid,
  output logic [DWIDTH-1:0] a_o_rsp0_rdata,
  output logic              a_o_rsp0_err,
  output logic              a_o_rsp1_valid,
  output logic [DWIDTH-1:0] a_o_rsp1_rdata,
  output logic              a_o_rsp1_err,
  output logic              a_o_mem_ce,
  output logic              a_o_mem_wr_en,
  output logic [3:0]        a_o_mem_mask,
  output logic [IDX_W-1:0]  a_o_mem_addr,
  output logic [DWIDTH-1:0] a_o_mem_wdata,
  input  logic [DWIDTH-1:0] a_i_mem_rdata
);

  import dmem_arbiter_pkg::*;

  localparam logic [31:0] DEPTH_LIM = 32'(MEM_DEPTH);

  state_e            state_q;
  logic              lastGrant_q;
  logic              portId_q;
  req_t              req_q;
  logic              memCe_q;
  logic              memWrEn_q;
  logic [3:0]        memMask_q;
  logic [IDX_W-1:0]  memAddr_q;
  logic [DWIDTH-1:0] memWdata_q;
  logic [1:0]        rspValid_q;
  logic [DWIDTH-1:0] rspRdata_q;
  logic              rspErr_q;

  logic              grant;
  logic              handshake;
  req_t              inReq;
  req_t              alignReq;
  logic [3:0]        alignMask;
  logic [DWIDTH-1:0] alignWdata;
  logic [DWIDTH-1:0] alignLoad;
  logic              misalign;
  logic              illegal;
  logic              legalStore;

  // Tie goes to the port that did not win the previous handshake.
  always_comb begin
    if (a_i_req0_valid && a_i_req1_valid) grant = ~lastGrant_q;
    else                                  grant = a_i_req1_valid;
  end

  assign handshake      = (state_q == ST_IDLE) && (a_i_req0_valid || a_i_req1_valid);
  assign a_o_req0_ready = handshake && !grant;
  assign a_o_req1_ready = handshake && grant;

  assign inReq = grant
    ? '{we: a_i_req1_we, size: a_i_req1_size, isUnsigned: a_i_req1_unsigned,
        addr: a_i_req1_addr, wdata: a_i_req1_wdata}
    : '{we: a_i_req0_we, size: a_i_req0_size, isUnsigned: a_i_req0_unsigned,
        addr: a_i_req0_addr, wdata: a_i_req0_wdata};

  // The lane logic serves the incoming request in IDLE and the captured one otherwise.
  assign alignReq = (state_q == ST_IDLE) ? inReq : req_q;

  dmem_lane_align u_align (
    .size_i     (alignReq.size),
    .off_i      (alignReq.addr[1:0]),
    .unsigned_i (alignReq.isUnsigned),
    .wdata_i    (alignReq.wdata),
    .rdata_i    (a_i_mem_rdata),
    .mask_o     (alignMask),
    .wdata_o    (alignWdata),
    .load_o     (alignLoad),
    .misalign_o (misalign)
  );

  assign illegal    = misalign || ({2'b00, alignReq.addr[31:2]} >= DEPTH_LIM);
  assign legalStore = !illegal && inReq.we;

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q     <= ST_IDLE;
      lastGrant_q <= 1'b1;
      portId_q    <= 1'b0;
      req_q       <= '0;
      memCe_q     <= 1'b0;
      memWrEn_q   <= 1'b0;
      memMask_q   <= '0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      rspValid_q  <= '0;
      rspRdata_q  <= '0;
      rspErr_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rspValid_q <= '0;
          rspRdata_q <= '0;
          rspErr_q   <= 1'b0;
          if (handshake) begin
            req_q       <= inReq;
            portId_q    <= grant;
            lastGrant_q <= grant;
            memCe_q     <= !illegal;
            memWrEn_q   <= legalStore;
            memMask_q   <= legalStore ? alignMask : 4'b0000;
            memAddr_q   <= inReq.addr[IDX_W+1:2];
            memWdata_q  <= legalStore ? alignWdata : '0;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          memCe_q    <= 1'b0;
          memWrEn_q  <= 1'b0;
          memMask_q  <= '0;
          memAddr_q  <= '0;
          memWdata_q <= '0;
          rspValid_q <= portId_q ? 2'b10 : 2'b01;
          rspErr_q   <= illegal;
          rspRdata_q <= (illegal || req_q.we) ? '0 : alignLoad;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          rspValid_q <= '0;
          rspRdata_q <= '0;
          rspErr_q   <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a_o_mem_ce     = memCe_q;
  assign a_o_mem_wr_en  = memWrEn_q;
  assign a_o_mem_mask   = memMask_q;
  assign a_o_mem_addr   = memAddr_q;
  assign a_o_mem_wdata  = memWdata_q;
  assign a_o_rsp0_valid = rspValid_q[0];
  assign a_o_rsp1_valid = rspValid_q[1];
  assign a_o_rsp0_rdata = rspValid_q[0] ? rspRdata_q : '0;
  assign a_o_rsp1_rdata = rspValid_q[1] ? rspRdata_q : '0;
  assign a_o_rsp0_err   = rspValid_q[0] && rspErr_q;
  assign a_o_rsp1_err   = rspValid_q[1] && rspErr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares them against what the DUT returns.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 0, we0 = 0, u0 = 0, v1 = 0, we1 = 0, u1 = 0;
  logic [1:0]  sz0 = 0, sz1 = 0;
  logic [31:0] ad0 = 0, wd0 = 0, ad1 = 0, wd1 = 0;
  logic        ready0, ready1, rspV0, rspV1, rspE0, rspE1;
  logic [31:0] rspD0, rspD1;
  logic        memCe, memWrEn;
  logic [3:0]  memMask;
  logic [4:0]  memAddr;
  logic [31:0] memWdata, memRdata;
  logic [31:0] mem [32];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   busy   = 0;
  logic tbLast = 1'b1;

  always #5 clk = ~clk;

  dmem_arbiter #(.DWIDTH(32), .MEM_DEPTH(32), .IDX_W(5)) dut (
    .a_clk(clk), .a_rst(rst),
    .a_i_req0_valid(v0), .a_o_req0_ready(ready0), .a_i_req0_we(we0),
    .a_i_req0_size(sz0), .a_i_req0_unsigned(u0), .a_i_req0_addr(ad0), .a_i_req0_wdata(wd0),
    .a_i_req1_valid(v1), .a_o_req1_ready(ready1), .a_i_req1_we(we1),
    .a_i_req1_size(sz1), .a_i_req1_unsigned(u1), .a_i_req1_addr(ad1), .a_i_req1_wdata(wd1),
    .a_o_rsp0_valid(rspV0), .a_o_rsp0_rdata(rspD0), .a_o_rsp0_err(rspE0),
    .a_o_rsp1_valid(rspV1), .a_o_rsp1_rdata(rspD1), .a_o_rsp1_err(rspE1),
    .a_o_mem_ce(memCe), .a_o_mem_wr_en(memWrEn), .a_o_mem_mask(memMask),
    .a_o_mem_addr(memAddr), .a_o_mem_wdata(memWdata), .a_i_mem_rdata(memRdata)
  );

  // Single-port memory model: combinational read, masked byte write.
  assign memRdata = mem[memAddr];
  always @(posedge clk) begin
    if (memCe && memWrEn)
      for (int b = 0; b < 4; b++)
        if (memMask[b]) mem[memAddr][8*b +: 8] <= memWdata[8*b +: 8];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Response monitor and ready-outside-IDLE watchdog.
  always @(negedge clk) begin
    exp_t e;
    if (rspV0) begin
      if (q0.size() == 0) checkOutput("rsp0_unexpected", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        checkOutput("rsp0_rdata", rspD0, e.rdata);
        checkOutput("rsp0_err", {31'b0, rspE0}, {31'b0, e.err});
      end
    end
    if (rspV1) begin
      if (q1.size() == 0) checkOutput("rsp1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        checkOutput("rsp1_rdata", rspD1, e.rdata);
        checkOutput("rsp1_err", {31'b0, rspE1}, {31'b0, e.err});
      end
    end
    if (rspV0 && rspV1) checkOutput("rsp_both_ports", 32'd1, 32'd0);
    if (rst) busy = 0;
    else if (busy > 0) begin
      checkOutput("ready_outside_idle", {31'b0, ready0 | ready1}, 32'd0);
      busy--;
    end else if (ready0 || ready1) busy = 2;
  end

  task automatic driveReq(input int port, input logic v, input logic we, input logic [1:0] sz,
                          input logic u, input logic [31:0] ad, input logic [31:0] wd);
    if (port == 0) begin v0 = v; we0 = we; sz0 = sz; u0 = u; ad0 = ad; wd0 = wd; end
    else           begin v1 = v; we1 = we; sz1 = sz; u1 = u; ad1 = ad; wd1 = wd; end
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [1:0] sz, input logic u,
                               input logic [31:0] ad, input logic [31:0] wd,
                               input logic [31:0] expRdata, input logic expErr,
                               input logic expCe, input logic expWrEn, input logic [3:0] expMask,
                               input logic [4:0] expIdx, input logic [31:0] expWdata,
                               input logic resetInAccess);
    exp_t e;
    logic got;
    e.rdata = expRdata;
    e.err   = expErr;
    if (!resetInAccess) begin
      if (port == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    driveReq(port, 1'b1, we, sz, u, ad, wd);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? ready0 : ready1;
    end
    if (!got) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      driveReq(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      if (!resetInAccess) begin
        if (port == 0) void'(q0.pop_back()); else void'(q1.pop_back());
      end
      return;
    end
    checkOutput("other_ready", {31'b0, (port == 0) ? ready1 : ready0}, 32'd0);
    @(posedge clk); #1;
    driveReq(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    tbLast = port[0];
    if (resetInAccess) rst = 1'b1;
    @(negedge clk);
    checkOutput("mem_ce", {31'b0, memCe}, {31'b0, expCe});
    checkOutput("mem_wr_en", {31'b0, memWrEn}, {31'b0, expWrEn});
    checkOutput("mem_mask", {28'b0, memMask}, {28'b0, expMask});
    if (expCe) checkOutput("mem_addr", {27'b0, memAddr}, {27'b0, expIdx});
    if (expWrEn) checkOutput("mem_wdata", memWdata, expWdata);
    @(posedge clk);
    if (resetInAccess) begin
      #1 rst = 1'b0;
      tbLast = 1'b1;
      @(negedge clk);
      checkOutput("rst_rsp_valid", {30'b0, rspV1, rspV0}, 32'd0);
      checkOutput("rst_mem_ctl", {29'b0, memCe, memWrEn, |memMask}, 32'd0);
      checkOutput("rst_mem_addr", {27'b0, memAddr}, 32'd0);
      checkOutput("rst_mem_wdata", memWdata, 32'd0);
    end else begin
      @(negedge clk);
    end
  endtask

  // Both ports valid with two word loads each; grants must alternate 0,1,0,1.
  task automatic applyTie();
    logic [31:0] adr0 [2];
    logic [31:0] adr1 [2];
    logic        expG [4];
    exp_t        e;
    int          n0, n1;
    logic        got, g;
    adr0[0] = 32'h04; adr0[1] = 32'h08;
    adr1[0] = 32'h18; adr1[1] = 32'h1C;
    expG[0] = 1'b0; expG[1] = 1'b1; expG[2] = 1'b0; expG[3] = 1'b1;
    e.err = 1'b0;
    e.rdata = 32'd1; q0.push_back(e);
    e.rdata = 32'd2; q0.push_back(e);
    e.rdata = 32'd6; q1.push_back(e);
    e.rdata = 32'd7; q1.push_back(e);
    n0 = 0; n1 = 0;
    @(posedge clk); #1;
    driveReq(0, 1'b1, 1'b0, 2'b10, 1'b0, adr0[0], 32'd0);
    driveReq(1, 1'b1, 1'b0, 2'b10, 1'b0, adr1[0], 32'd0);
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = ready0 || ready1;
      end
      if (!got) begin
        checkOutput("tie_ready_timeout", 32'd0, 32'd1);
        break;
      end
      g = ready1;
      checkOutput("tie_grant", {31'b0, g}, {31'b0, expG[k]});
      checkOutput("tie_single_ready", {31'b0, ready0 & ready1}, 32'd0);
      @(posedge clk); #1;
      tbLast = g;
      if (!g) begin
        n0++;
        if (n0 < 2) driveReq(0, 1'b1, 1'b0, 2'b10, 1'b0, adr0[n0], 32'd0);
        else        driveReq(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      end else begin
        n1++;
        if (n1 < 2) driveReq(1, 1'b1, 1'b0, 2'b10, 1'b0, adr1[n1], 32'd0);
        else        driveReq(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      end
    end
    driveReq(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    driveReq(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = i;
    mem[0] = 32'h8000_1234;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_rsp_valid", {30'b0, rspV1, rspV0}, 32'd0);
    checkOutput("reset_mem_ctl", {29'b0, memCe, memWrEn, |memMask}, 32'd0);
    checkOutput("reset_mem_addr", {27'b0, memAddr}, 32'd0);
    checkOutput("reset_ready_idle", {30'b0, ready1, ready0}, 32'd0);

    //            port we sz     u     addr      wdata          expRdata       err  ce   wr   mask     idx    expWdata       rstA
    applyStimulus(0, 0, 2'b10, 1'b0, 32'h0C, 32'h0,         32'h0000_0003, 0,   1,   0,   4'b0000, 5'd3,  32'h0,         0);
    applyStimulus(1, 1, 2'b00, 1'b0, 32'h11, 32'h0000_00A5, 32'h0,         0,   1,   1,   4'b0010, 5'd4,  32'hA5A5_A5A5, 0);
    applyStimulus(0, 0, 2'b00, 1'b0, 32'h11, 32'h0,         32'hFFFF_FFA5, 0,   1,   0,   4'b0000, 5'd4,  32'h0,         0);
    applyStimulus(1, 0, 2'b00, 1'b1, 32'h11, 32'h0,         32'h0000_00A5, 0,   1,   0,   4'b0000, 5'd4,  32'h0,         0);
    applyStimulus(0, 0, 2'b01, 1'b0, 32'h02, 32'h0,         32'hFFFF_8000, 0,   1,   0,   4'b0000, 5'd0,  32'h0,         0);
    applyStimulus(0, 0, 2'b01, 1'b1, 32'h02, 32'h0,         32'h0000_8000, 0,   1,   0,   4'b0000, 5'd0,  32'h0,         0);
    applyStimulus(1, 0, 2'b01, 1'b0, 32'h03, 32'h0,         32'h0,         1,   0,   0,   4'b0000, 5'd0,  32'h0,         0);
    applyStimulus(0, 1, 2'b10, 1'b0, 32'h80, 32'hDEAD_BEEF, 32'h0,         1,   0,   0,   4'b0000, 5'd0,  32'h0,         0);
    applyStimulus(1, 0, 2'b10, 1'b0, 32'h00, 32'h0,         32'h8000_1234, 0,   1,   0,   4'b0000, 5'd0,  32'h0,         0);
    applyStimulus(0, 1, 2'b01, 1'b0, 32'h16, 32'h0000_BEEF, 32'h0,         0,   1,   1,   4'b1100, 5'd5,  32'hBEEF_BEEF, 0);
    applyStimulus(1, 0, 2'b10, 1'b0, 32'h14, 32'h0,         32'hBEEF_0005, 0,   1,   0,   4'b0000, 5'd5,  32'h0,         0);
    applyStimulus(0, 1, 2'b11, 1'b0, 32'h08, 32'h1234_5678, 32'h0,         1,   0,   0,   4'b0000, 5'd0,  32'h0,         0);
    applyStimulus(1, 1, 2'b10, 1'b0, 32'h06, 32'h1234_5678, 32'h0,         1,   0,   0,   4'b0000, 5'd0,  32'h0,         0);
    applyStimulus(0, 0, 2'b10, 1'b0, 32'h08, 32'h0,         32'h0,         0,   1,   0,   4'b0000, 5'd2,  32'h0,         1);
    applyTie();

    checkOutput("word0_unchanged", mem[0], 32'h8000_1234);
    checkOutput("q0_drained", q0.size(), 32'd0);
    checkOutput("q1_drained", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
